cache_resp: RTL and testbench

Cache-side responder for the `cpu_if` request channel. It runs entirely in the `c_clk` domain, accepts the `c_rd`/`c_wr` requests that `cpu_if` issues, and services them from a direct-mapped word store with byte-enable writes. It returns `c_rdata` and a single-cycle `c_ack` after a fixed latency. Until the real cache controller lands, it stands in for it on the far end of `cpu_if`.

---
 rtl/cache_resp.sv | 204 ++++++++++++++++++++
 tb/tb_cache_resp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cache_resp.sv
// ---------------------------------------------------------------------------
// cache_resp
//   Cache-side responder for the cpu_if request channel. Requests are served
//   from a direct-mapped word store with byte-enable writes. Each request gets
//   exactly one c_ack pulse after a fixed latency of LAT wait cycles.
//
//   Parameters
//     IDX_W   : index width, the store holds 2^IDX_W 32-bit words
//     LAT     : extra wait cycles between capture and ack (0..15)
//
//   Ports
//     c_clk   in   : clock, all state updates on the rising edge
//     sys_rst in   : synchronous active-high reset
//     c_addr  in 16: word address, only c_addr[IDX_W-1:0] is used (aliasing)
//     c_rd    in   : read request level, held until c_ack is seen
//     c_wr    in   : write request level, wins over c_rd when both are high
//     c_wdata in 32: write data
//     c_bval  in 4 : byte enables, bit i covers c_wdata[8i+7:8i]
//     c_rdata out32: read data, loaded on read completion and held
//     c_ack   out  : one-cycle completion pulse per request
//     busy    out  : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module cache_resp #(
    parameter int IDX_W = 8,
    parameter int LAT   = 2
) (
    input  logic        c_clk,
    input  logic        sys_rst,
    input  logic [15:0] c_addr,
    input  logic        c_rd,
    input  logic        c_wr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_bval,
    output logic [31:0] c_rdata,
    output logic        c_ack,
    output logic        busy
);

    localparam int         DEPTH = 1 << IDX_W;
    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [31:0]        wdata_r;
    logic [3:0]         bval_r;
    logic               is_wr_r;

    logic [31:0]        mem_r [DEPTH];
    logic [DEPTH-1:0]   valid_r;

    logic               req_s;
    logic               commit_s;
    logic               do_write_s;
    logic               old_valid_s;
    logic [31:0]        old_word_s;
    logic [31:0]        rd_word_s;
    logic [31:0]        merged_s;
    logic               unused_addr_s;

    // Byte-merge of new data into a stored word; disabled bytes of a word
    // that was never written read back as zero rather than stale array data.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_word,
        input logic        old_valid,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_word[8*i +: 8];
            end else if (old_valid) begin
                m[8*i +: 8] = old_word[8*i +: 8];
            end else begin
                m[8*i +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

    // Upper address bits alias onto the same word and are deliberately unused.
    assign unused_addr_s = ^c_addr[15:IDX_W];

    // Request detect, commit strobe and store read/merge datapath.
    always_comb begin
        req_s       = c_rd | c_wr;
        commit_s    = (state_r == ST_BUSY) && (cnt_r == 4'd0);
        // A write with no byte enabled is acked but touches neither array nor valid bit.
        do_write_s  = commit_s && is_wr_r && (bval_r != 4'b0000);
        old_valid_s = valid_r[idx_r];
        old_word_s  = mem_r[idx_r];
        if (old_valid_s) begin
            rd_word_s = old_word_s;
        end else begin
            rd_word_s = 32'h0000_0000;
        end
        merged_s    = merge_word(old_word_s, old_valid_s, wdata_r, bval_r);
    end

    // Next-state logic for IDLE -> BUSY -> ACK -> WAIT_REL -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (commit_s) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_ACK: begin
                state_s = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                // Held requests are parked here so they are never serviced twice.
                if (req_s) begin
                    state_s = ST_WAIT_REL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge c_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture and latency counter.
    always_ff @(posedge c_clk) begin
        if (sys_rst) begin
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            wdata_r <= 32'h0000_0000;
            bval_r  <= 4'b0000;
            is_wr_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            cnt_r   <= LAT_C;
            idx_r   <= c_addr[IDX_W-1:0];
            wdata_r <= c_wdata;
            bval_r  <= c_bval;
            is_wr_r <= c_wr;
        end else if ((state_r == ST_BUSY) && (cnt_r != 4'd0)) begin
            cnt_r   <= cnt_r - 4'd1;
        end
    end

    // Registered outputs: ack pulse, read data and busy flag.
    always_ff @(posedge c_clk) begin
        if (sys_rst) begin
            c_ack   <= 1'b0;
            c_rdata <= 32'h0000_0000;
            busy    <= 1'b0;
        end else begin
            c_ack <= commit_s;
            busy  <= (state_s != ST_IDLE);
            if (commit_s && !is_wr_r) begin
                c_rdata <= rd_word_s;
            end
        end
    end

    // Valid-bit vector; cleared by reset so the whole store reads as zero.
    always_ff @(posedge c_clk) begin
        if (sys_rst) begin
            valid_r <= '0;
        end else if (do_write_s) begin
            valid_r[idx_r] <= 1'b1;
        end
    end

    // Word array, not reset; a commit coinciding with reset is dropped.
    always_ff @(posedge c_clk) begin
        if (!sys_rst && do_write_s) begin
            mem_r[idx_r] <= merged_s;
        end
    end

endmodule

// File: tb/tb_cache_resp.sv
module tb_cache_resp;

    logic        c_clk;
    logic        sys_rst;
    logic [15:0] c_addr;
    logic        c_rd;
    logic        c_wr;
    logic [31:0] c_wdata;
    logic [3:0]  c_bval;
    logic [31:0] c_rdata;
    logic        c_ack;
    logic        busy;

    int checks;
    int failures;

    cache_resp #(.IDX_W(8), .LAT(2)) dut (
        .c_clk   (c_clk),
        .sys_rst (sys_rst),
        .c_addr  (c_addr),
        .c_rd    (c_rd),
        .c_wr    (c_wr),
        .c_wdata (c_wdata),
        .c_bval  (c_bval),
        .c_rdata (c_rdata),
        .c_ack   (c_ack),
        .busy    (busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    // Issue one request, hold it hold_extra cycles past the ack, then release
    // and wait for the responder to return to idle. ack_edge counts edges after
    // the capture edge (expected 1+LAT), -1 if no ack was seen.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [31:0] wd, input logic [3:0] bv,
                          input int hold_extra,
                          output logic [31:0] rdata_o, output int ack_edge,
                          output int acks, output logic busy_k0,
                          output logic busy_k1, output logic busy_drop);
        ack_edge  = -1;
        acks      = 0;
        rdata_o   = 32'hDEAD_BEEF;
        busy_k0   = 1'b0;
        busy_k1   = 1'b0;
        busy_drop = 1'b0;
        @(negedge c_clk);
        c_rd = rd; c_wr = wr; c_addr = a; c_wdata = wd; c_bval = bv;
        for (int n = 1; n <= 40; n++) begin
            @(posedge c_clk); #1;
            if (n == 1) busy_k0 = busy;
            if (n == 2) busy_k1 = busy;
            if (c_ack) begin
                acks++;
                if (ack_edge < 0) begin
                    ack_edge = n - 1;
                    rdata_o  = c_rdata;
                end
            end
            if (ack_edge >= 0 && (c_rd || c_wr) && n > ack_edge + 1 && !busy)
                busy_drop = 1'b1;
            if (ack_edge >= 0 && n >= ack_edge + 1 + hold_extra) begin
                c_rd = 1'b0; c_wr = 1'b0;
            end
            if (ack_edge >= 0 && !c_ack && !busy && !c_rd && !c_wr) break;
        end
        c_rd = 1'b0; c_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int ae, na; logic b0, b1, bd;
        sys_rst = 1'b1;
        repeat (3) @(posedge c_clk);
        #1;
        checks++; if (c_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", c_ack); end
        checks++; if (c_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", c_rdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge c_clk); sys_rst = 1'b0;
        do_req(1'b1, 1'b0, 16'h010F, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL first_rd_busy got=%b exp=1", b1); end
        checks++; if (ae !== 3) begin failures++; $display("FAIL first_rd_latency got=%0d exp=3", ae); end
        checks++; if (na !== 1) begin failures++; $display("FAIL first_rd_acks got=%0d exp=1", na); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL first_rd_data got=%h exp=00000000", rd); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd; int ae, na; logic b0, b1, bd;
        do_req(1'b0, 1'b1, 16'h010F, 32'h0001_2343, 4'b0010, 0, rd, ae, na, b0, b1, bd);
        checks++; if (na !== 1) begin failures++; $display("FAIL bw_wr_acks got=%0d exp=1", na); end
        do_req(1'b1, 1'b0, 16'h010F, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (na !== 1) begin failures++; $display("FAIL bw_rd_acks got=%0d exp=1", na); end
        checks++; if (rd !== 32'h0000_2300) begin failures++; $display("FAIL bw_rd_data got=%h exp=00002300", rd); end
    endtask

    task automatic test_alias();
        logic [31:0] rd; int ae, na; logic b0, b1, bd;
        do_req(1'b0, 1'b1, 16'h0005, 32'h1234_ABCD, 4'b1111, 0, rd, ae, na, b0, b1, bd);
        do_req(1'b0, 1'b1, 16'h0105, 32'h0000_00EE, 4'b0001, 0, rd, ae, na, b0, b1, bd);
        do_req(1'b1, 1'b0, 16'h0005, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (rd !== 32'h1234_ABEE) begin failures++; $display("FAIL alias_data got=%h exp=1234abee", rd); end
    endtask

    task automatic test_hold();
        logic [31:0] rd; int ae, na; logic b0, b1, bd;
        do_req(1'b0, 1'b1, 16'h0040, 32'hA5A5_5A5A, 4'b1111, 5, rd, ae, na, b0, b1, bd);
        checks++; if (na !== 1) begin failures++; $display("FAIL hold_acks got=%0d exp=1", na); end
        checks++; if (bd !== 1'b0) begin failures++; $display("FAIL hold_busy_dropped got=%b exp=0", bd); end
        do_req(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL hold_next_capture got=%b exp=1", b0); end
        checks++; if (ae !== 3) begin failures++; $display("FAIL hold_next_latency got=%0d exp=3", ae); end
        checks++; if (rd !== 32'hA5A5_5A5A) begin failures++; $display("FAIL hold_rd_data got=%h exp=a5a55a5a", rd); end
    endtask

    task automatic test_rd_wr_both();
        logic [31:0] rd; int ae, na; logic b0, b1, bd;
        do_req(1'b1, 1'b1, 16'h0020, 32'hCAFE_F00D, 4'b1111, 0, rd, ae, na, b0, b1, bd);
        checks++; if (na !== 1) begin failures++; $display("FAIL both_acks got=%0d exp=1", na); end
        checks++; if (rd !== 32'hA5A5_5A5A) begin failures++; $display("FAIL both_rdata_kept got=%h exp=a5a55a5a", rd); end
        do_req(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL both_rd_data got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_zero_bval();
        logic [31:0] rd; int ae, na; logic b0, b1, bd;
        do_req(1'b0, 1'b1, 16'h0007, 32'h1122_3344, 4'b1111, 0, rd, ae, na, b0, b1, bd);
        do_req(1'b0, 1'b1, 16'h0007, 32'hFFFF_FFFF, 4'b0000, 0, rd, ae, na, b0, b1, bd);
        checks++; if (na !== 1) begin failures++; $display("FAIL zbv_acks got=%0d exp=1", na); end
        do_req(1'b1, 1'b0, 16'h0007, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (rd !== 32'h1122_3344) begin failures++; $display("FAIL zbv_rd_data got=%h exp=11223344", rd); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; int ae, na; logic b0, b1, bd; int late_acks;
        do_req(1'b0, 1'b1, 16'h0009, 32'h5566_7788, 4'b1111, 0, rd, ae, na, b0, b1, bd);
        late_acks = 0;
        @(negedge c_clk);
        c_wr = 1'b1; c_rd = 1'b0; c_addr = 16'h0003; c_wdata = 32'hFFFF_FFFF; c_bval = 4'b1111;
        @(posedge c_clk); #1;                        // edge k: capture
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_k got=%b exp=1", busy); end
        @(posedge c_clk); #1;                        // edge k+1
        if (c_ack) late_acks++;
        @(negedge c_clk); sys_rst = 1'b1; c_wr = 1'b0;
        @(posedge c_clk); #1;                        // edge k+2: reset
        if (c_ack) late_acks++;
        @(negedge c_clk); sys_rst = 1'b0;
        @(posedge c_clk); #1;                        // edge k+3
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy_k3 got=%b exp=0", busy); end
        checks++; if (c_rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_rdata got=%h exp=00000000", c_rdata); end
        if (c_ack) late_acks++;
        repeat (4) begin @(posedge c_clk); #1; if (c_ack) late_acks++; end
        checks++; if (late_acks !== 0) begin failures++; $display("FAIL rst_mid_no_ack got=%0d exp=0", late_acks); end
        do_req(1'b1, 1'b0, 16'h0003, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_mid_dropped_wr got=%h exp=00000000", rd); end
        do_req(1'b1, 1'b0, 16'h0009, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_mid_valid_clr got=%h exp=00000000", rd); end
        do_req(1'b0, 1'b1, 16'h0009, 32'h0000_00AB, 4'b0001, 0, rd, ae, na, b0, b1, bd);
        do_req(1'b1, 1'b0, 16'h0009, 32'h0, 4'h0, 0, rd, ae, na, b0, b1, bd);
        checks++; if (rd !== 32'h0000_00AB) begin failures++; $display("FAIL rst_mid_invalid_merge got=%h exp=000000ab", rd); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sys_rst  = 1'b1;
        c_addr   = 16'h0000;
        c_rd     = 1'b0;
        c_wr     = 1'b0;
        c_wdata  = 32'h0000_0000;
        c_bval   = 4'b0000;
        test_reset();
        test_byte_write();
        test_alias();
        test_hold();
        test_rd_wr_both();
        test_zero_bval();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
